// File: rtl/audioport_pkg.sv
// Shared types and constants for the DSP command scheduler.
// Command bit indices double as the issue priority order (lowest index wins).
package audioport_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } sched_state_e;

    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 255;

    localparam int unsigned NUM_CMD   = 4;
    localparam int unsigned CMD_TICK  = 0;
    localparam int unsigned CMD_CLR   = 1;
    localparam int unsigned CMD_CFG   = 2;
    localparam int unsigned CMD_LEVEL = 3;

endpackage

// File: rtl/dsp_cmd_scheduler.sv
// Fixed-priority command scheduler that sequences tick/clr/cfg/level pulses to a DSP datapath.
// Optional BUSY watchdog is compiled in with DSP_SCHED_WATCHDOG_EN.
module dsp_cmd_scheduler
    import audioport_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
    parameter int unsigned OVR_W          = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_req,
    input  logic             cfg_req,
    input  logic             level_req,
    input  logic             clr_req,
    input  logic             dsp_done_in,
    output logic             tick_out,
    output logic             cfg_out,
    output logic             level_out,
    output logic             clr_out,
    output logic             busy_out,
    output logic [OVR_W-1:0] overrun_out,
    output logic             timeout_out
);

    // One-hot grant of the highest-priority pending command.
    function automatic logic [NUM_CMD-1:0] pick_cmd(input logic [NUM_CMD-1:0] pend);
        logic [NUM_CMD-1:0] grant;
        grant = '0;
        if (pend[CMD_TICK])       grant[CMD_TICK]  = 1'b1;
        else if (pend[CMD_CLR])   grant[CMD_CLR]   = 1'b1;
        else if (pend[CMD_CFG])   grant[CMD_CFG]   = 1'b1;
        else if (pend[CMD_LEVEL]) grant[CMD_LEVEL] = 1'b1;
        return grant;
    endfunction

    sched_state_e       state_q, state_d;
    logic [NUM_CMD-1:0] flag_q, flag_d;
    logic [NUM_CMD-1:0] pulse_q;
    logic [NUM_CMD-1:0] req_c, pend_c, issue_c;
    logic [OVR_W-1:0]   ovr_q, ovr_d;
    logic               busy_q;
    logic               timeout_q;
    logic               can_issue_c;
    logic               tick_drop_c;
    logic               wd_expire_c;

    always_comb begin
        req_c            = '0;
        req_c[CMD_TICK]  = tick_req;
        req_c[CMD_CLR]   = clr_req;
        req_c[CMD_CFG]   = cfg_req;
        req_c[CMD_LEVEL] = level_req;
        pend_c           = flag_q | req_c;
        state_d          = state_q;
        can_issue_c      = 1'b0;

        // The cycle after a tick pulse is spent entering BUSY, so nothing issues then.
        case (state_q)
            IDLE: begin
                if (pulse_q[CMD_TICK]) begin
                    state_d = BUSY;
                end else begin
                    can_issue_c = 1'b1;
                end
            end
            BUSY: begin
                if (dsp_done_in || wd_expire_c) begin
                    state_d     = IDLE;
                    can_issue_c = 1'b1;
                end
            end
        endcase

        issue_c = can_issue_c ? pick_cmd(pend_c) : '0;

        // Issued flag keeps only a fresh request that collided with a stored one.
        flag_d = (issue_c & flag_q & req_c) | (~issue_c & pend_c);

        tick_drop_c = tick_req & flag_q[CMD_TICK] & ~issue_c[CMD_TICK];

        ovr_d = ovr_q;
        if (issue_c[CMD_CLR]) begin
            ovr_d = '0;
        end else if (tick_drop_c && (ovr_q != {OVR_W{1'b1}})) begin
            ovr_d = ovr_q + OVR_W'(1);
        end
    end

`ifdef DSP_SCHED_WATCHDOG_EN
    localparam int unsigned WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [WD_W-1:0] wd_q, wd_d;

    // Counts BUSY cycles; zero on every BUSY entry.
    always_comb begin
        wd_d        = '0;
        wd_expire_c = 1'b0;
        if (state_q == BUSY) begin
            wd_expire_c = !dsp_done_in && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
            if (state_d == BUSY) begin
                wd_d = wd_q + WD_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`else
    logic unused_timeout_cfg;

    assign wd_expire_c        = 1'b0;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            flag_q    <= '0;
            pulse_q   <= '0;
            ovr_q     <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            flag_q    <= flag_d;
            pulse_q   <= issue_c;
            ovr_q     <= ovr_d;
            busy_q    <= (state_d == BUSY);
            timeout_q <= wd_expire_c;
        end
    end

    assign tick_out    = pulse_q[CMD_TICK];
    assign clr_out     = pulse_q[CMD_CLR];
    assign cfg_out     = pulse_q[CMD_CFG];
    assign level_out   = pulse_q[CMD_LEVEL];
    assign busy_out    = busy_q;
    assign overrun_out = ovr_q;
    assign timeout_out = timeout_q;

endmodule
